// File: rtl/serdes_strobe_deser.sv
// serdes_strobe_deser
//   Receive-side deserializer clocked by IOCLK. Serial bits from D are shifted
//   into a DATA_WIDTH-bit register. Each SERDESSTROBE pulse marks a word
//   boundary and captures one parallel word. The strobe period is monitored
//   and reported as a lock indication plus a sticky error flag. BITSLIP drops
//   one incoming bit to move the word boundary.
//
// Ports
//   IOCLK        in   fast I/O clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   D            in   serial data, sampled every edge
//   SERDESSTROBE in   one-cycle word-capture strobe
//   BITSLIP      in   drop the current bit (at most once per word)
//   ERR_CLR      in   synchronous clear of STROBE_ERR
//   Q            out  captured word, first-received bit at the MSB
//   Q_VALID      out  one-cycle pulse when Q updates
//   LOCKED       out  strobe period verified
//   STROBE_ERR   out  sticky strobe-period error
module serdes_strobe_deser #(
  parameter int DATA_WIDTH = 4,
  parameter int LOCK_COUNT = 3
) (
  input  logic                  IOCLK,
  input  logic                  RST_N,
  input  logic                  D,
  input  logic                  SERDESSTROBE,
  input  logic                  BITSLIP,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VALID,
  output logic                  LOCKED,
  output logic                  STROBE_ERR
);

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_e;

  localparam logic [3:0] PERIOD  = 4'(DATA_WIDTH);
  localparam logic [3:0] LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0] CNT_MAX = 4'hF;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  qv_q, qv_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            good_q, good_d;
  logic                  seen_q, seen_d;
  logic                  bs_used_q, bs_used_d;

  logic [DATA_WIDTH-1:0] shifted;
  logic                  slip_ok;
  logic [3:0]            good_inc;
  logic                  err_set;

  // The capture includes the bit arriving on the strobe edge itself.
  assign shifted  = {sr_q[DATA_WIDTH-2:0], D};
  // A slip on a strobe edge is ignored; otherwise only the first slip of a word counts.
  assign slip_ok  = BITSLIP && !SERDESSTROBE && !bs_used_q;
  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    q_d       = q_q;
    qv_d      = 1'b0;
    cnt_d     = cnt_q;
    good_d    = good_q;
    seen_d    = seen_q;
    bs_used_d = bs_used_q;
    err_set   = 1'b0;

    if (!slip_ok) begin
      sr_d = shifted;
    end

    // cnt holds the number of edges since the last strobe, as seen on this edge.
    if (SERDESSTROBE) begin
      q_d       = shifted;
      qv_d      = 1'b1;
      cnt_d     = 4'd1;
      bs_used_d = 1'b0;
    end else begin
      if (slip_ok) begin
        bs_used_d = 1'b1;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    case (state_q)
      ST_ACQUIRE: begin
        if (SERDESSTROBE) begin
          seen_d = 1'b1;
          // The first strobe after reset or a missing-strobe error only opens an interval.
          if (seen_q) begin
            if (cnt_q == PERIOD) begin
              good_d = good_inc;
              if (good_inc == LOCK_N) begin
                state_d = ST_LOCKED;
              end
            end else begin
              good_d = 4'd0;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (SERDESSTROBE) begin
          // Early strobe: it still starts a fresh interval, so seen stays set.
          if (cnt_q < PERIOD) begin
            err_set = 1'b1;
            state_d = ST_ACQUIRE;
            good_d  = 4'd0;
            seen_d  = 1'b1;
          end
        end else if (cnt_q == PERIOD) begin
          // Missing strobe: no valid interval start remains.
          err_set = 1'b1;
          state_d = ST_ACQUIRE;
          good_d  = 4'd0;
          seen_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACQUIRE;
      end
    endcase

    // An error detected on the same edge as ERR_CLR keeps the flag set.
    if (err_set) begin
      err_d = 1'b1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_ACQUIRE;
      sr_q      <= '0;
      q_q       <= '0;
      qv_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 4'd0;
      good_q    <= 4'd0;
      seen_q    <= 1'b0;
      bs_used_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      q_q       <= q_d;
      qv_q      <= qv_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      seen_q    <= seen_d;
      bs_used_q <= bs_used_d;
    end
  end

  assign Q          = q_q;
  assign Q_VALID    = qv_q;
  assign LOCKED     = locked_q;
  assign STROBE_ERR = err_q;

endmodule

// File: tb/tb_serdes_strobe_deser.sv
// Bench for serdes_strobe_deser (DATA_WIDTH=4, LOCK_COUNT=3): a table of
// directed vectors for capture and lock, hand sequences for missing/early
// strobes, bitslip and mid-word reset, then randomized traffic compared
// against an edge-indexed behavioural model.
module tb_serdes_strobe_deser;

  localparam int W  = 4;
  localparam int LC = 3;

  logic         clk;
  logic         rst_n;
  logic         d, strb, bs, clr;
  logic [W-1:0] q;
  logic         qv, lk, er;

  int checks;
  int errors;

  serdes_strobe_deser #(.DATA_WIDTH(W), .LOCK_COUNT(LC)) dut (
    .IOCLK       (clk),
    .RST_N       (rst_n),
    .D           (d),
    .SERDESSTROBE(strb),
    .BITSLIP     (bs),
    .ERR_CLR     (clr),
    .Q           (q),
    .Q_VALID     (qv),
    .LOCKED      (lk),
    .STROBE_ERR  (er)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Bits are kept as a history of accepted samples; time is an edge index.
  bit           hist[$];
  bit           slip_taken;
  bit           have_last;
  int           now_e;
  int           last_strb;
  int           run;
  bit           m_locked;
  bit           m_err;
  logic [W-1:0] m_q;
  bit           m_v;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    slip_taken = 0; have_last = 0; now_e = 0; last_strb = 0; run = 0;
    m_locked = 0; m_err = 0; m_q = '0; m_v = 0;
  endtask

  task automatic model_step(input logic di, input logic si, input logic bi, input logic ci);
    bit ev;
    int gap;
    ev = 0;
    now_e++;
    gap = now_e - last_strb;
    if (si) begin
      hist.push_back(di);
      while (hist.size() > W) void'(hist.pop_front());
      for (int i = 0; i < W; i++) m_q[W-1-i] = hist[i];
      m_v = 1;
      if (m_locked) begin
        if (gap < W) begin ev = 1; m_locked = 0; run = 0; end
      end else if (have_last) begin
        if (gap == W) run++; else run = 0;
        if (run == LC) m_locked = 1;
      end
      have_last = 1; last_strb = now_e; slip_taken = 0;
    end else begin
      m_v = 0;
      if (bi && !slip_taken) slip_taken = 1;
      else begin
        hist.push_back(di);
        while (hist.size() > W) void'(hist.pop_front());
      end
      if (m_locked && have_last && gap == W) begin
        ev = 1; m_locked = 0; run = 0; have_last = 0;
      end
    end
    if (ev) m_err = 1;
    else if (ci) m_err = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic di, input logic si, input logic bi, input logic ci);
    d = di; strb = si; bs = bi; clr = ci;
    model_step(di, si, bi, ci);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic di, input logic si, input logic bi, input logic ci);
    apply(di, si, bi, ci);
    chk("q", 32'(q), 32'(m_q));
    chk("q_valid", 32'(qv), 32'(m_v));
    chk("locked", 32'(lk), 32'(m_locked));
    chk("strobe_err", 32'(er), 32'(m_err));
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_q_valid", 32'(qv), 32'h0);
    chk("rst_locked", 32'(lk), 32'h0);
    chk("rst_strobe_err", 32'(er), 32'h0);
    model_reset();
    d = 0; strb = 0; bs = 0; clr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic pat(input int e);
    return ((e % 4) == 2) || ((e % 4) == 3);
  endfunction

  typedef struct {
    logic         d, s, b, c;
    logic [W-1:0] q;
    logic         v, lk, er;
  } vec_t;

  function automatic vec_t mk(input logic di, input logic si, input logic [W-1:0] qi,
                              input logic vi, input logic li);
    vec_t r;
    r.d = di; r.s = si; r.b = 1'b0; r.c = 1'b0;
    r.q = qi; r.v = vi; r.lk = li; r.er = 1'b0;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int since;
    int target;
    checks = 0; errors = 0;

    tbl[0]  = mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 4'b1011, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 4'b0110, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 4'b1110, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 4'b1110, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 4'b1110, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 4'b1110, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 1'b1, 4'b0011, 1'b1, 1'b1);

    rst_n = 1'b0; d = 0; strb = 0; bs = 0; clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_q_valid", 32'(qv), 32'h0);
    chk("reset_locked", 32'(lk), 32'h0);
    chk("reset_strobe_err", 32'(er), 32'h0);
    rst_n = 1'b1;

    // Basic capture and lock acquisition, edges 0..15.
    for (int e = 0; e < 16; e++) begin
      apply(tbl[e].d, tbl[e].s, tbl[e].b, tbl[e].c);
      chk($sformatf("tbl%0d_q", e), 32'(q), 32'(tbl[e].q));
      chk($sformatf("tbl%0d_q_valid", e), 32'(qv), 32'(tbl[e].v));
      chk($sformatf("tbl%0d_locked", e), 32'(lk), 32'(tbl[e].lk));
      chk($sformatf("tbl%0d_strobe_err", e), 32'(er), 32'(tbl[e].er));
    end

    // Missing strobe at edge 19, ERR_CLR at edge 25, relock by edge 35.
    for (int e = 16; e < 40; e++) begin
      cyc(1'($urandom_range(0, 1)), (e % 4) == 3 && e != 19, 1'b0, e == 25);
      if (e == 19) begin
        chk("missing_err", 32'(er), 32'h1);
        chk("missing_unlock", 32'(lk), 32'h0);
      end
      if (e == 24) chk("err_sticky", 32'(er), 32'h1);
      if (e == 25) chk("err_clr", 32'(er), 32'h0);
      if (e == 34) chk("relock_pending", 32'(lk), 32'h0);
      if (e == 35) chk("relock", 32'(lk), 32'h1);
    end

    // Early strobe at edge 41; strobes at 45, 49, 53 relock.
    for (int e = 40; e < 54; e++) begin
      cyc(1'($urandom_range(0, 1)), e == 41 || e == 45 || e == 49 || e == 53, 1'b0, 1'b0);
      if (e == 41) begin
        chk("early_capture", 32'(qv), 32'h1);
        chk("early_err", 32'(er), 32'h1);
        chk("early_unlock", 32'(lk), 32'h0);
      end
      if (e == 49) chk("early_relock_pending", 32'(lk), 32'h0);
      if (e == 53) chk("early_relock", 32'(lk), 32'h1);
    end

    // Bitslip on a repeating 1,1,0,0 stream, strobes on edges with e%4==1.
    for (int e = 54; e < 76; e++) begin
      cyc(pat(e), (e % 4) == 1, e == 64 || e == 66 || e == 67 || e == 73, 1'b0);
      if (e == 61) chk("slip_aligned", 32'(q), 32'b1100);
      if (e == 65) chk("slip_once", 32'(q), 32'b0110);
      if (e == 69) chk("slip_second_ignored", 32'(q), 32'b0100);
      if (e == 73) chk("slip_on_strobe_ignored", 32'(q), 32'b1100);
    end

    // Reset mid-word while locked, then the lock sequence restarts.
    do_reset();
    for (int e = 0; e < 16; e++) begin
      cyc(1'($urandom_range(0, 1)), (e % 4) == 3, 1'b0, 1'b0);
      if (e == 2) chk("post_rst_no_valid", 32'(qv), 32'h0);
      if (e == 14) chk("post_rst_lock_pending", 32'(lk), 32'h0);
      if (e == 15) chk("post_rst_lock", 32'(lk), 32'h1);
    end

    // Randomized traffic with mostly regular, sometimes jittered strobes.
    since = 0;
    target = 4;
    for (int i = 0; i < 3000; i++) begin
      logic s;
      since++;
      s = (since >= target);
      if (s) begin
        since = 0;
        target = ($urandom_range(0, 19) < 16) ? 4 : int'($urandom_range(1, 7));
      end
      cyc(1'($urandom_range(0, 1)), s, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        since = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
